instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: FETCH -> EXEC -> FETCH sequencer with branch redirect and sticky HALT.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] IMemAddr,
   output logic        IMemReq,
   input  logic        IMemValid,
   input  logic [31:0] IMemRData,
   input  logic        NextPCSrc,
   input  logic [31:0] ALURes,
   input  logic        Hold,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCInc,
   output logic        InstrValid,
   output logic [1:0]  Fault
);

   localparam logic [1:0]  ST_FETCH = 2'd0;
   localparam logic [1:0]  ST_EXEC  = 2'd1;
   localparam logic [1:0]  ST_HALT  = 2'd2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic [1:0]  state_reg;
   logic [31:0] pc_reg;
   logic [31:0] instr_reg;
   logic [1:0]  fault_reg;
   logic        run_reg;
   logic        timeout_hit;
   logic [31:0] target;
   logic        unused_alu_lsb;

   assign target         = {ALURes[31:1], 1'b0};
   assign unused_alu_lsb = ALURes[0];

`ifdef FETCH_TIMEOUT_EN
   localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYC);
   logic [7:0] cnt_reg;

   // Counts consecutive FETCH cycles without data; idle in any other state so entry to FETCH starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= 8'd0;
      end else if (run_reg) begin
         if (state_reg != ST_FETCH || IMemValid) begin
            cnt_reg <= 8'd0;
         end else begin
            cnt_reg <= cnt_reg + 8'd1;
         end
      end
   end

   assign timeout_hit = (({1'b0, cnt_reg} + 9'd1) == TO_LIM);
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign timeout_hit    = 1'b0;
`endif

   // run_reg holds the machine idle for the first edge after reset release and
   // kills the request/commit strobes asynchronously while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_FETCH;
         pc_reg    <= RESET_PC;
         instr_reg <= NOP;
         fault_reg <= 2'b00;
         run_reg   <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         if (run_reg) begin
            case (state_reg)
               ST_FETCH: begin
                  if (IMemValid) begin
                     instr_reg <= IMemRData;
                     state_reg <= ST_EXEC;
                  end else if (timeout_hit) begin
                     fault_reg <= 2'b10;
                     state_reg <= ST_HALT;
                  end
               end
               ST_EXEC: begin
                  if (!Hold) begin
                     if (!NextPCSrc) begin
                        pc_reg    <= pc_reg + 32'd4;
                        state_reg <= ST_FETCH;
                     end else if (!target[1]) begin
                        pc_reg    <= target;
                        state_reg <= ST_FETCH;
                     end else begin
                        fault_reg <= 2'b01;
                        state_reg <= ST_HALT;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign IMemAddr   = pc_reg;
   assign IMemReq    = run_reg && (state_reg == ST_FETCH);
   assign InstrValid = run_reg && (state_reg == ST_EXEC);
   assign Instr      = instr_reg;
   assign PC         = pc_reg;
   assign PCInc      = pc_reg + 32'd4;
   assign Fault      = fault_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch; the reference model tracks the architectural PC per instruction.
// Timeout checks follow FETCH_TIMEOUT_EN when it is defined.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] IMemAddr;
   logic        IMemReq;
   logic        IMemValid;
   logic [31:0] IMemRData;
   logic        NextPCSrc;
   logic [31:0] ALURes;
   logic        Hold;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCInc;
   logic        InstrValid;
   logic [1:0]  Fault;

   int          tests;
   int          fails;
   logic [31:0] exp_pc;
   logic        exp_halt;

   instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYC(255)) dut (
      .clk(clk), .rst_n(rst_n), .IMemAddr(IMemAddr), .IMemReq(IMemReq),
      .IMemValid(IMemValid), .IMemRData(IMemRData), .NextPCSrc(NextPCSrc),
      .ALURes(ALURes), .Hold(Hold), .Instr(Instr), .PC(PC), .PCInc(PCInc),
      .InstrValid(InstrValid), .Fault(Fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench on a negedge with the DUT in its first requesting FETCH cycle.
   task automatic do_reset();
      rst_n = 1'b0; IMemValid = 1'b0; IMemRData = '0; NextPCSrc = 1'b0; ALURes = '0; Hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      exp_pc   = RST_PC;
      exp_halt = 1'b0;
   endtask

   // One instruction: lat empty FETCH cycles, accept data, hold extra EXEC cycles, then resolve.
   task automatic run_instr(input int lat, input int hold, input logic br, input logic [31:0] alu, input logic [31:0] data);
      logic [31:0] tgt;
      logic [31:0] exp_inc;
      exp_inc = exp_pc + 32'd4;
      $display("[TB] instr pc=%h lat=%0d hold=%0d br=%0d alu=%h data=%h", exp_pc, lat, hold, br, alu, data);
      for (int i = 0; i <= lat; i++) begin
         tests++;
         if (IMemReq !== 1'b1 || IMemAddr !== exp_pc || InstrValid !== 1'b0) begin
            fails++;
            $display("FAIL fetch: req=%b addr=%h iv=%b, required req=1 addr=%h iv=0", IMemReq, IMemAddr, InstrValid, exp_pc);
         end
         IMemValid = (i == lat);
         IMemRData = (i == lat) ? data : $urandom;
         next_cycle();
      end
      for (int j = 0; j <= hold; j++) begin
         tests++;
         if (InstrValid !== 1'b1 || IMemReq !== 1'b0 || Instr !== data || PC !== exp_pc || PCInc !== exp_inc || Fault !== 2'b00) begin
            fails++;
            $display("FAIL exec: iv=%b req=%b instr=%h pc=%h inc=%h fault=%b, required iv=1 req=0 instr=%h pc=%h inc=%h fault=00",
                     InstrValid, IMemReq, Instr, PC, PCInc, Fault, data, exp_pc, exp_inc);
         end
         IMemValid = $urandom_range(0, 1);
         IMemRData = $urandom;
         Hold      = (j < hold);
         NextPCSrc = (j < hold) ? 1'($urandom_range(0, 1)) : br;
         ALURes    = (j < hold) ? $urandom : alu;
         next_cycle();
      end
      Hold = 1'b0; NextPCSrc = 1'b0; IMemValid = 1'b0;
      if (br) begin
         tgt = alu & 32'hFFFF_FFFE;
         if (tgt[1]) exp_halt = 1'b1;
         else exp_pc = tgt;
      end else begin
         exp_pc = exp_inc;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; IMemValid = 1'b0; IMemRData = '0; NextPCSrc = 1'b0; ALURes = '0; Hold = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || Fault !== 2'b00 || PC !== RST_PC || Instr !== NOP || PCInc !== RST_PC + 32'd4) begin
         fails++;
         $display("FAIL reset_state: req=%b iv=%b fault=%b pc=%h instr=%h inc=%h", IMemReq, InstrValid, Fault, PC, Instr, PCInc);
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (IMemReq !== 1'b0) begin
         fails++;
         $display("FAIL reset_release_early_req: req=%b, required 0 before first edge", IMemReq);
      end
      @(negedge clk);
      tests++;
      if (IMemReq !== 1'b1 || IMemAddr !== RST_PC) begin
         fails++;
         $display("FAIL first_request: req=%b addr=%h, required req=1 addr=%h", IMemReq, IMemAddr, RST_PC);
      end
      exp_pc = RST_PC; exp_halt = 1'b0;
   endtask

   task automatic test_sequential();
      do_reset();
      for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, 32'h0, 32'h0050_0093);
      tests++;
      if (IMemAddr !== 32'h0000_000C || IMemReq !== 1'b1) begin
         fails++;
         $display("FAIL seq_addr: addr=%h req=%b, required addr=0000000c req=1", IMemAddr, IMemReq);
      end
   endtask

   task automatic test_branch_misaligned();
      do_reset();
      run_instr(0, 0, 1'b1, 32'h0000_0101, 32'hA5A5_0001);
      tests++;
      if (IMemAddr !== 32'h0000_0100) begin
         fails++;
         $display("FAIL jalr_target: addr=%h, required 00000100", IMemAddr);
      end
      run_instr(1, 0, 1'b1, 32'h0000_0103, 32'hA5A5_0002);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || Fault !== 2'b01 || PC !== 32'h0000_0100 || Instr !== 32'hA5A5_0002) begin
            fails++;
            $display("FAIL halt_misaligned: req=%b iv=%b fault=%b pc=%h instr=%h, required req=0 iv=0 fault=01 pc=00000100 instr=a5a50002",
                     IMemReq, InstrValid, Fault, PC, Instr);
         end
         IMemValid = 1'b1; IMemRData = $urandom; NextPCSrc = 1'b1; ALURes = $urandom;
         next_cycle();
      end
      IMemValid = 1'b0; NextPCSrc = 1'b0;
   endtask

   task automatic test_hold();
      int iv_cnt;
      do_reset();
      run_instr(0, 0, 1'b0, 32'h0, 32'h1111_1111);
      run_instr(3, 2, 1'b0, 32'h0, 32'h2222_2222);
      // Independent re-count of commit cycles for a second instruction with the same shape.
      iv_cnt = 0;
      repeat (3) next_cycle();
      IMemValid = 1'b1; IMemRData = 32'h3333_3333;
      next_cycle();
      IMemValid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (InstrValid === 1'b1) iv_cnt++;
         Hold = (c < 2);
         next_cycle();
      end
      Hold = 1'b0;
      tests++;
      if (iv_cnt != 3 || PC !== 32'h0000_000C) begin
         fails++;
         $display("FAIL hold_count: iv_cycles=%0d pc=%h, required 3 and 0000000c", iv_cnt, PC);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      run_instr(0, 0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0013);
      run_instr(2, 1, 1'b0, 32'h0, 32'h0050_0093);
      tests++;
      if (IMemAddr !== 32'h0000_0000 || IMemReq !== 1'b1) begin
         fails++;
         $display("FAIL wrap_addr: addr=%h req=%b, required 00000000 req=1", IMemAddr, IMemReq);
      end
   endtask

   task automatic test_random();
      logic        br;
      logic [31:0] alu;
      do_reset();
      for (int t = 0; t < 40; t++) begin
         br  = ($urandom_range(0, 3) == 0);
         alu = $urandom & 32'hFFFF_FFFD;
         run_instr($urandom_range(0, 3), $urandom_range(0, 2), br, alu, $urandom);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      run_instr(0, 0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || PC !== RST_PC || Instr !== NOP) begin
         fails++;
         $display("FAIL reset_midfetch: req=%b iv=%b pc=%h instr=%h", IMemReq, InstrValid, PC, Instr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      tests++;
      if (IMemReq !== 1'b1 || IMemAddr !== RST_PC || Instr !== NOP) begin
         fails++;
         $display("FAIL reset_release: req=%b addr=%h instr=%h", IMemReq, IMemAddr, Instr);
      end
      IMemValid = 1'b1; IMemRData = 32'h0BAD_F00D; Hold = 1'b1;
      next_cycle();
      IMemValid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (InstrValid !== 1'b0 || IMemReq !== 1'b0 || Instr !== NOP) begin
         fails++;
         $display("FAIL reset_midexec: iv=%b req=%b instr=%h", InstrValid, IMemReq, Instr);
      end
      Hold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
      do_reset();
      for (int i = 0; i < 254; i++) next_cycle();
      tests++;
      if (IMemReq !== 1'b1 || Fault !== 2'b00) begin
         fails++;
         $display("FAIL timeout_early: req=%b fault=%b after 254 cycles, required req=1 fault=00", IMemReq, Fault);
      end
      next_cycle();
      tests++;
      if (IMemReq !== 1'b0 || Fault !== 2'b10 || InstrValid !== 1'b0) begin
         fails++;
         $display("FAIL timeout_fault: req=%b fault=%b iv=%b, required req=0 fault=10 iv=0", IMemReq, Fault, InstrValid);
      end
      do_reset();
      for (int i = 0; i < 254; i++) next_cycle();
      IMemValid = 1'b1; IMemRData = 32'h1234_5678;
      next_cycle();
      IMemValid = 1'b0;
      tests++;
      if (InstrValid !== 1'b1 || Fault !== 2'b00 || Instr !== 32'h1234_5678) begin
         fails++;
         $display("FAIL timeout_valid_wins: iv=%b fault=%b instr=%h, required iv=1 fault=00 instr=12345678", InstrValid, Fault, Instr);
      end
      next_cycle();
`else
      int req_low;
      do_reset();
      req_low = 0;
      for (int i = 0; i < 1000; i++) begin
         if (IMemReq !== 1'b1 || Fault === 2'b10) req_low++;
         next_cycle();
      end
      tests++;
      if (req_low != 0 || IMemReq !== 1'b1 || Fault !== 2'b00) begin
         fails++;
         $display("FAIL no_timeout: bad_cycles=%0d req=%b fault=%b, required 0 req=1 fault=00", req_low, IMemReq, Fault);
      end
`endif
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_sequential();
      test_branch_misaligned();
      test_hold();
      test_wrap();
      test_random();
      test_reset_midflight();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
